pwm_audio_out: RTL and testbench
================================

PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

Interface
REQ-001 Parameter: DIV, default 1, clock cycles per PWM count tick; legal range 1..256.
REQ-002 Parameter: IDLE_LEVEL, default 8'h80, sample loaded when no sample is available at start of run.
REQ-003 Clocking/reset: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  system clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: enable  in  1  run request; 1 = generate PWM, 0 = stop at next period boundary.
REQ-007 Port: sample_in  in  8  unsigned mixed audio sample from the mixer.
REQ-008 Port: sample_valid  in  1  sample_in valid this cycle.
REQ-009 Port: sample_ready  out  1  block can accept a sample this cycle.
REQ-010 Port: underrun_clr  in  1  clears the underrun flag.
REQ-011 Port: pwm_out  out  1  registered PWM audio output.
REQ-012 Port: period_start  out  1  one-cycle pulse when a new active sample takes effect.
REQ-013 Port: underrun  out  1  sticky flag: a period began with no fresh sample.

Function
REQ-014 Handshake: transfer occurs when sample_valid && sample_ready; sample_valid may assert independent of sample_ready.
REQ-015 Buffer: one-entry holding register next_sample with flag next_full; sample_ready = !next_full && !rst.
REQ-016 Tick generator: prescaler counts 0..DIV-1; tick asserts for one cycle when it equals DIV-1; with DIV=1, tick asserts every cycle.
REQ-017 Period counter: 8-bit cnt advances on tick from 0 to 254, then wraps to 0; the period is 255 ticks.
REQ-018 Compare: pwm_out <= (cnt < active_sample) in RUN and DRAIN; pwm_out <= 0 in IDLE. One-cycle latency from cnt to pwm_out.
REQ-019 Compare consequences: 0x00 yields pwm_out always low; 0xFF yields pwm_out always high over a period.
REQ-020 States: IDLE, RUN, DRAIN.
REQ-021 IDLE: cnt and prescaler are held at 0, and samples are still accepted, so the buffer can be primed.
REQ-022 IDLE -> RUN when enable=1.
REQ-023 Entry load: on entering RUN, active_sample loads next_sample if next_full, otherwise IDLE_LEVEL; next_full clears; period_start pulses; underrun is not set.
REQ-024 Wrap: a wrap is a tick with cnt=254 in RUN.
REQ-025 Wrap with next_full=1: active_sample <= next_sample; next_full <= 0.
REQ-026 Wrap with next_full=0 and a transfer in the same cycle: sample_in bypasses directly to active_sample; next_full stays 0; no underrun.
REQ-027 Wrap with next_full=0 and no transfer: active_sample is retained; underrun <= 1.
REQ-028 Every wrap pulses period_start.
REQ-029 RUN -> DRAIN when enable=0 while cnt != 254 or no tick is present.
REQ-030 RUN -> IDLE directly when enable=0 coincides with a wrap; active_sample is not reloaded.
REQ-031 DRAIN finishes the current period, then -> IDLE on the tick with cnt=254. There is no reload and no period_start pulse; enable re-asserting in DRAIN is ignored until IDLE.
REQ-032 Underrun flag: underrun_clr=1 clears underrun; if underrun_clr and a set event occur in the same cycle, set wins.

Reset
REQ-033 While rst=1, every output and register is reset on the next clk edge: state=IDLE, cnt=0, prescaler=0, next_full=0, active_sample=IDLE_LEVEL, pwm_out=0, period_start=0, underrun=0, sample_ready=0.
REQ-034 Reset mid-period abandons the period immediately; no drain.
REQ-035 sample_ready=1 on the first cycle after rst deasserts.

Structure
REQ-036 Shared package audio_pkg holds SAMPLE_W=8, PWM_MAX=8'd254 and the state enum {IDLE, RUN, DRAIN}.
REQ-037 Sub-module tick_gen (prescaler, parameter DIV, outputs tick) is instantiated once; all other logic is local.

Verification (DIV=1, IDLE_LEVEL=8'h80)
REQ-038 Priming: reset, push 0x40 while in IDLE, then enable=1 -> period_start pulse; pwm_out high for exactly 64 of the next 255 cycles; period_start repeats every 255 cycles.
REQ-039 Extremes: active sample 0x00 -> pwm_out 0 for all 255 cycles; active sample 0xFF -> pwm_out 1 for all 255 cycles.
REQ-040 Underrun: push only 0x80 -> second period again 128 high cycles and underrun=1 after the wrap; underrun_clr pulse -> underrun=0; a same-cycle clr and set -> underrun=1.
REQ-041 Backpressure and bypass:
- Hold valid with 0x10 then 0x20 -> sample_ready=0 after 0x10 is accepted; sample_ready=1 the cycle after the wrap; 0x20 is then accepted.
- Valid 0x30 on the wrap cycle with empty buffer -> next period shows 48 high cycles and underrun stays 0.
REQ-042 Disable: enable=0 at cnt=100 -> pwm pattern continues through cnt=254, then IDLE with pwm_out=0 and cnt=0.
REQ-043 Reset mid-run: rst=1 for one cycle at cnt=50 -> next cycle all outputs and state match REQ-033.

Source files
------------

// File: rtl/audio_pkg.sv
// ============================================================================
// audio_pkg : shared widths, period limit and state encoding for PWM audio
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] PWM_MAX = 8'd254;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Last count of a period: the 255-tick period runs 0..PWM_MAX.
  function automatic logic is_last(input logic [SAMPLE_W-1:0] cnt);
    return cnt == PWM_MAX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : prescaler producing a one-cycle tick every DIV clocks while run_i
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen
  import audio_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] C_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Held at zero whenever not running so a new run starts phase-aligned.
  always_comb begin
    pre_d = pre_q;
    if (!run_i) begin
      pre_d = '0;
    end else if (pre_q == C_LAST) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick_o = run_i && (pre_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/pwm_audio_out.sv
// ============================================================================
// pwm_audio_out : 8-bit PWM audio DAC with one-entry sample buffer and underrun
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_audio_out
  import audio_pkg::*;
#(
  parameter int                  DIV        = 1,
  parameter logic [SAMPLE_W-1:0] IDLE_LEVEL = 8'h80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic                pwm_out,
  output logic                period_start,
  output logic                underrun
);

  state_t              state_q,     state_d;
  logic [SAMPLE_W-1:0] cnt_q,       cnt_d;
  logic [SAMPLE_W-1:0] active_q,    active_d;
  logic [SAMPLE_W-1:0] next_q,      next_d;
  logic                next_full_q, next_full_d;
  logic                pwm_q,       pwm_d;
  logic                pstart_q,    pstart_d;
  logic                underrun_q,  underrun_d;

  logic tick;
  logic transfer;
  logic last_tick;
  logic ur_set;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .run_i  (state_q != IDLE),
    .tick_o (tick)
  );

  assign sample_ready = !next_full_q && !rst;
  assign transfer     = sample_valid && sample_ready;
  assign last_tick    = tick && is_last(cnt_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    next_d      = next_q;
    next_full_d = next_full_q;
    pwm_d       = 1'b0;
    pstart_d    = 1'b0;
    ur_set      = 1'b0;

    if (transfer) begin
      next_d      = sample_in;
      next_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d  = RUN;
          pstart_d = 1'b1;
          if (next_full_q) begin
            active_d    = next_q;
            next_full_d = 1'b0;
          end else begin
            active_d = IDLE_LEVEL;
          end
        end
      end

      RUN: begin
        pwm_d = cnt_q < active_q;
        if (tick) begin
          cnt_d = last_tick ? '0 : cnt_q + 8'd1;
        end
        if (!enable) begin
          state_d = last_tick ? IDLE : DRAIN;
        end else if (last_tick) begin
          pstart_d = 1'b1;
          if (next_full_q) begin
            active_d    = next_q;
            next_full_d = 1'b0;
          end else if (transfer) begin
            // Sample arriving exactly on the wrap skips the buffer.
            active_d    = sample_in;
            next_full_d = 1'b0;
          end else begin
            ur_set = 1'b1;
          end
        end
      end

      DRAIN: begin
        pwm_d = cnt_q < active_q;
        if (tick) begin
          cnt_d = last_tick ? '0 : cnt_q + 8'd1;
        end
        if (last_tick) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (ur_set) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      active_q    <= IDLE_LEVEL;
      next_q      <= '0;
      next_full_q <= 1'b0;
      pwm_q       <= 1'b0;
      pstart_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      next_q      <= next_d;
      next_full_q <= next_full_d;
      pwm_q       <= pwm_d;
      pstart_q    <= pstart_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;
  assign underrun     = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_audio_out.sv
// ============================================================================
// tb_pwm_audio_out : directed self-checking bench for pwm_audio_out (DIV=1)
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_audio_out;
  import audio_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       underrun_clr = 1'b0;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;

  int n_checks = 0;
  int n_fails  = 0;

  pwm_audio_out #(
    .DIV        (1),
    .IDLE_LEVEL (8'h80)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; underrun_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic push(input logic [7:0] s, output bit ok);
    ok = 1'b0;
    sample_in = s; sample_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (sample_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_pstart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on a period_start cycle; counts the 255 following cycles.
  task automatic count_period(output int hi, output int ps);
    hi = 0; ps = 0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (i == 0) sample_valid = 1'b0;
      hi += int'(pwm_out);
      ps += int'(period_start);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; underrun_clr = 1'b0;
    step(); step();
    n_checks++;
    if ({pwm_out, period_start, underrun, sample_ready} !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b expected 0000", {pwm_out, period_start, underrun, sample_ready});
    end
    n_checks++;
    if (dut.state_q !== IDLE || dut.cnt_q !== 8'd0 || dut.active_q !== 8'h80) begin
      n_fails++;
      $display("FAIL reset_state: state %0d cnt %0d active %h expected 0 0 80", dut.state_q, dut.cnt_q, dut.active_q);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (sample_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL ready_after_reset: got %b expected 1", sample_ready);
    end
  endtask

  task automatic test_priming;
    bit ok; int hi, ps;
    do_reset();
    push(8'h40, ok);
    enable = 1'b1;
    wait_pstart(ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL prime_pstart: got timeout expected pulse");
    end
    count_period(hi, ps);
    n_checks++;
    if (hi !== 64) begin
      n_fails++;
      $display("FAIL prime_high: got %0d expected 64", hi);
    end
    n_checks++;
    if (ps !== 1 || period_start !== 1'b1) begin
      n_fails++;
      $display("FAIL prime_repeat: got %0d pulses last %b expected 1 pulse at 255", ps, period_start);
    end
  endtask

  task automatic test_extremes;
    bit ok; int hi, ps;
    do_reset();
    push(8'h00, ok);
    enable = 1'b1;
    wait_pstart(ok);
    sample_in = 8'hFF; sample_valid = 1'b1;
    count_period(hi, ps);
    n_checks++;
    if (hi !== 0) begin
      n_fails++;
      $display("FAIL extreme_00: got %0d expected 0", hi);
    end
    count_period(hi, ps);
    n_checks++;
    if (hi !== 255) begin
      n_fails++;
      $display("FAIL extreme_ff: got %0d expected 255", hi);
    end
  endtask

  task automatic test_underrun;
    bit ok; int hi, ps;
    do_reset();
    push(8'h80, ok);
    enable = 1'b1;
    wait_pstart(ok);
    count_period(hi, ps);
    n_checks++;
    if (underrun !== 1'b1 || period_start !== 1'b1) begin
      n_fails++;
      $display("FAIL underrun_set: got ur %b ps %b expected 1 1", underrun, period_start);
    end
    count_period(hi, ps);
    n_checks++;
    if (hi !== 128) begin
      n_fails++;
      $display("FAIL underrun_retain: got %0d expected 128", hi);
    end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fails++;
      $display("FAIL underrun_clr: got %b expected 0", underrun);
    end
    repeat (253) step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    n_checks++;
    if (underrun !== 1'b1 || period_start !== 1'b1) begin
      n_fails++;
      $display("FAIL underrun_set_wins: got ur %b ps %b expected 1 1", underrun, period_start);
    end
  endtask

  task automatic test_back_to_back;
    bit ok; int hi, ps;
    do_reset();
    enable = 1'b1;
    wait_pstart(ok);
    sample_in = 8'h10; sample_valid = 1'b1;
    step();
    sample_in = 8'h20;
    n_checks++;
    if (sample_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_ready_low: got %b expected 0", sample_ready);
    end
    repeat (253) step();
    n_checks++;
    if (sample_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_ready_held: got %b expected 0", sample_ready);
    end
    step();
    n_checks++;
    if (sample_ready !== 1'b1 || period_start !== 1'b1) begin
      n_fails++;
      $display("FAIL bp_ready_after_wrap: got rdy %b ps %b expected 1 1", sample_ready, period_start);
    end
    count_period(hi, ps);
    n_checks++;
    if (hi !== 16) begin
      n_fails++;
      $display("FAIL bp_sample10: got %0d expected 16", hi);
    end
    n_checks++;
    if (sample_ready !== 1'b1 || underrun !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_consumed20: got rdy %b ur %b expected 1 0", sample_ready, underrun);
    end
    repeat (254) step();
    sample_in = 8'h30; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    n_checks++;
    if (period_start !== 1'b1 || sample_ready !== 1'b1 || underrun !== 1'b0) begin
      n_fails++;
      $display("FAIL bypass_wrap: got ps %b rdy %b ur %b expected 1 1 0", period_start, sample_ready, underrun);
    end
    count_period(hi, ps);
    n_checks++;
    if (hi !== 48) begin
      n_fails++;
      $display("FAIL bypass_high: got %0d expected 48", hi);
    end
  endtask

  task automatic test_disable;
    bit ok; int hi, ps;
    do_reset();
    push(8'hC8, ok);
    enable = 1'b1;
    wait_pstart(ok);
    repeat (100) step();
    enable = 1'b0;
    step();
    n_checks++;
    if (dut.state_q !== DRAIN) begin
      n_fails++;
      $display("FAIL disable_drain: got state %0d expected %0d", dut.state_q, DRAIN);
    end
    hi = int'(pwm_out); ps = 0;
    for (int i = 0; i < 153; i++) begin
      step();
      hi += int'(pwm_out);
      ps += int'(period_start);
    end
    n_checks++;
    if (hi !== 100 || ps !== 0) begin
      n_fails++;
      $display("FAIL disable_tail: got high %0d pulses %0d expected 100 0", hi, ps);
    end
    step();
    n_checks++;
    if (dut.state_q !== IDLE || dut.cnt_q !== 8'd0 || pwm_out !== 1'b0 || period_start !== 1'b0) begin
      n_fails++;
      $display("FAIL disable_idle: got state %0d cnt %0d pwm %b ps %b expected 0 0 0 0",
               dut.state_q, dut.cnt_q, pwm_out, period_start);
    end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    do_reset();
    push(8'h90, ok);
    enable = 1'b1;
    wait_pstart(ok);
    repeat (50) step();
    rst = 1'b1; enable = 1'b0;
    step();
    n_checks++;
    if ({pwm_out, period_start, underrun, sample_ready} !== 4'b0000) begin
      n_fails++;
      $display("FAIL midrun_outputs: got %b expected 0000", {pwm_out, period_start, underrun, sample_ready});
    end
    n_checks++;
    if (dut.state_q !== IDLE || dut.cnt_q !== 8'd0 || dut.active_q !== 8'h80 || dut.next_full_q !== 1'b0) begin
      n_fails++;
      $display("FAIL midrun_state: got state %0d cnt %0d active %h full %b expected 0 0 80 0",
               dut.state_q, dut.cnt_q, dut.active_q, dut.next_full_q);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (sample_ready !== 1'b1 || pwm_out !== 1'b0) begin
      n_fails++;
      $display("FAIL midrun_release: got rdy %b pwm %b expected 1 0", sample_ready, pwm_out);
    end
  endtask

  initial begin
    test_reset();
    test_priming();
    test_extremes();
    test_underrun();
    test_back_to_back();
    test_disable();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
